mac_seq_ctrl: RTL and testbench

Sequencer for the 24-bit Q1.23 MAC block. It computes one dot product (FIR output sample) per Start:
- issues a coefficient-memory read and a sample-ring-buffer read per tap;
- drives the MAC Clr/WrEn strobes, aligned to the one-cycle memory read latency;
- captures the MAC's truncated output and presents it on a valid/ready result port.

It sits between the tap memories, the MAC and the downstream consumer, such as a decimator or output FIFO.

---
 rtl/mac_seq_pkg.sv | 17 +
 rtl/mac_seq_addr_gen.sv | 46 ++++
 rtl/mac_seq_ctrl.sv | 96 +++++++++
 tb/tb_mac_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default sizing for the MAC dot-product sequencer.
// Tap memories are DEPTH entries; the tap count is one bit wider so DEPTH itself is expressible.
package mac_seq_pkg;

  localparam int WIDTH_DEF      = 24;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int LEN_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
  localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Tap counter with coefficient/sample address generation; addresses follow k combinationally.
// Sample address walks backwards from the newest sample and wraps modulo DEPTH.
module mac_seq_addr_gen #(
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] coeff_addr,
  output logic [ADDR_WIDTH-1:0] samp_addr,
  output logic                  first,
  output logic                  last
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  logic [LEN_WIDTH-1:0]  k;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      len_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      k      <= '0;
      len_q  <= (len > MAX_LEN) ? MAX_LEN : len;
      base_q <= base;
    end else if (step) begin
      k <= k + ONE;
    end
  end

  // Address-width subtraction gives the ring wrap for free.
  assign coeff_addr = k[ADDR_WIDTH-1:0];
  assign samp_addr  = base_q - k[ADDR_WIDTH-1:0];
  assign first      = (k == '0);
  assign last       = (k == len_q - ONE);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one FIR dot product per Start: Len reads, MAC strobes one cycle later, result after DRAIN.
// Result is ready at t+Len+2 (t+1 for Len=0); DONE holds the result indefinitely until ResultReady_SI.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [LEN_WIDTH-1:0]  Len_DI,
  input  logic [ADDR_WIDTH-1:0] SampBase_DI,
  output logic                  Busy_SO,
  output logic                  MemRdEn_SO,
  output logic [ADDR_WIDTH-1:0] CoeffAddr_DO,
  output logic [ADDR_WIDTH-1:0] SampAddr_DO,
  output logic                  MacClr_SO,
  output logic                  MacWrEn_SO,
  input  logic [WIDTH-1:0]      MacOut_DI,
  output logic [WIDTH-1:0]      Result_DO,
  output logic                  ResultValid_SO,
  input  logic                  ResultReady_SI
);

  state_t state, state_nxt;

  logic             accept;
  logic             rd_en;
  logic             first;
  logic             last;
  logic             clr_q;
  logic             wren_q;
  logic             last_q;
  logic [WIDTH-1:0] result_q;

  assign accept = (state == IDLE) && Start_SI;
  assign rd_en  = (state == RUN);

  mac_seq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk        (Clk_CI),
    .rst        (Rst_RI),
    .load       (accept),
    .step       (rd_en),
    .len        (Len_DI),
    .base       (SampBase_DI),
    .coeff_addr (CoeffAddr_DO),
    .samp_addr  (SampAddr_DO),
    .first      (first),
    .last       (last)
  );

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state    <= IDLE;
      clr_q    <= 1'b0;
      wren_q   <= 1'b0;
      last_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_nxt;
      // Strobes trail the read by the one-cycle memory latency.
      wren_q <= rd_en;
      clr_q  <= rd_en && first;
      last_q <= rd_en && last;
      if (accept && (Len_DI == '0)) begin
        result_q <= '0;
      end else if (last_q && wren_q) begin
        result_q <= MacOut_DI;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_SI) state_nxt = (Len_DI == '0) ? DONE : RUN;
      RUN:     if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (ResultReady_SI) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy_SO        = (state != IDLE);
  assign MemRdEn_SO     = rd_en;
  assign MacClr_SO      = clr_q;
  assign MacWrEn_SO     = wren_q;
  assign Result_DO      = result_q;
  assign ResultValid_SO = (state == DONE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with behavioural Q1.23 MAC, 1-cycle tap memories and a result scoreboard.
module tb_mac_seq_ctrl;

  localparam int W  = 24;
  localparam int AW = 5;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] base = '0;
  logic          busy;
  logic          mem_rd;
  logic [AW-1:0] caddr;
  logic [AW-1:0] saddr;
  logic          mac_clr;
  logic          mac_wr;
  logic [W-1:0]  mac_out;
  logic [W-1:0]  res;
  logic          res_vld;
  logic          ready = 1'b0;

  logic [W-1:0]  cmem [32];
  logic [W-1:0]  smem [32];
  logic [W-1:0]  coeff_q = '0;
  logic [W-1:0]  samp_q = '0;
  logic [W-1:0]  acc = '0;
  logic [W-1:0]  exp_q [$];

  int total = 0;
  int bad = 0;
  int n_rd = 0, n_wr = 0, n_clr = 0, n_clr_orphan = 0, n_first_noclr = 0;
  logic wr_prev = 1'b0;
  logic [AW-1:0] ca_log [$];
  logic [AW-1:0] sa_log [$];

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .Clk_CI         (clk),
    .Rst_RI         (rst),
    .Start_SI       (start),
    .Len_DI         (len),
    .SampBase_DI    (base),
    .Busy_SO        (busy),
    .MemRdEn_SO     (mem_rd),
    .CoeffAddr_DO   (caddr),
    .SampAddr_DO    (saddr),
    .MacClr_SO      (mac_clr),
    .MacWrEn_SO     (mac_wr),
    .MacOut_DI      (mac_out),
    .Result_DO      (res),
    .ResultValid_SO (res_vld),
    .ResultReady_SI (ready)
  );

  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] x, y, p;
    x = {{W{a[W-1]}}, a};
    y = {{W{b[W-1]}}, b};
    p = (x * y) >>> (W - 1);
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] golden(input int l, input int b);
    int n;
    logic [W-1:0] s;
    n = (l > 32) ? 32 : l;
    s = '0;
    for (int i = 0; i < n; i++) s = s + qmul(cmem[i], smem[(b - i) & 31]);
    return s;
  endfunction

  // Behavioural MAC and tap memories
  always_comb mac_out = (mac_clr ? '0 : acc) + qmul(coeff_q, samp_q);

  always @(posedge clk) begin
    if (mem_rd) begin
      coeff_q <= cmem[caddr];
      samp_q  <= smem[saddr];
    end
    if (mac_wr) acc <= mac_out;
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      n_rd++;
      ca_log.push_back(caddr);
      sa_log.push_back(saddr);
    end
    if (mac_wr) n_wr++;
    if (mac_clr) n_clr++;
    if (mac_clr && !mac_wr) n_clr_orphan++;
    if (mac_wr && !wr_prev && !mac_clr) n_first_noclr++;
    wr_prev = mac_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one Start, wait for the result, optionally hold off Ready, then pop and compare.
  task automatic run(input string tag, input int l, input int b, input int hold, output int lat);
    int c;
    int rd0, wr0;
    logic [W-1:0] e;
    exp_q.push_back(golden(l, b));
    len   = LW'(l);
    base  = AW'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (!res_vld && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    lat = c;
    if (!res_vld) chk({tag, " timeout"}, 32'(res_vld), 32'd1);
    e = exp_q.pop_front();
    rd0 = n_rd;
    wr0 = n_wr;
    for (int i = 0; i < hold; i++) begin
      chk({tag, " hold res"}, 32'(res), 32'(e));
      chk({tag, " hold vld"}, 32'(res_vld), 32'd1);
      chk({tag, " hold busy"}, 32'(busy), 32'd1);
      start = ~start;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (hold > 0) begin
      chk({tag, " hold reads"}, 32'(n_rd - rd0), 32'd0);
      chk({tag, " hold writes"}, 32'(n_wr - wr0), 32'd0);
    end
    chk({tag, " result"}, 32'(res), 32'(e));
    ready = 1'b1;
    start = (hold > 0);
    @(posedge clk); #1;
    ready = 1'b0;
    start = 1'b0;
    chk({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, r0, w0, c0, idx;
    int exp_sa [4];
    exp_sa = '{1, 0, 31, 30};
    for (int i = 0; i < 32; i++) begin
      cmem[i] = 24'h400000;
      smem[i] = 24'h200000;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rd", 32'(mem_rd), 32'd0);
    chk("rst caddr", 32'(caddr), 32'd0);
    chk("rst saddr", 32'(saddr), 32'd0);
    chk("rst clr", 32'(mac_clr), 32'd0);
    chk("rst wr", 32'(mac_wr), 32'd0);
    chk("rst res", 32'(res), 32'd0);
    chk("rst vld", 32'(res_vld), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic run: 4 x 0.5*0.25 = 0.5
    r0 = n_rd; w0 = n_wr; c0 = n_clr;
    run("t1", 4, 3, 0, lat);
    chk("t1 const result", 32'(golden(4, 3)), 32'h400000);
    chk("t1 latency", 32'(lat), 32'd6);
    chk("t1 wr pulses", 32'(n_wr - w0), 32'd4);
    chk("t1 clr pulses", 32'(n_clr - c0), 32'd1);
    chk("t1 clr orphan", 32'(n_clr_orphan), 32'd0);
    chk("t1 clr aligned", 32'(n_first_noclr), 32'd0);

    // Ring wrap with random data
    for (int i = 0; i < 32; i++) begin
      cmem[i] = W'($urandom);
      smem[i] = W'($urandom);
    end
    idx = ca_log.size();
    run("t2", 4, 1, 0, lat);
    for (int j = 0; j < 4; j++) begin
      chk("t2 caddr", 32'(ca_log[idx + j]), 32'(j));
      chk("t2 saddr", 32'(sa_log[idx + j]), 32'(exp_sa[j]));
    end

    // Zero length and clamped length
    r0 = n_rd; w0 = n_wr;
    run("t3 len0", 0, 5, 0, lat);
    chk("t3 len0 latency", 32'(lat), 32'd1);
    chk("t3 len0 reads", 32'(n_rd - r0), 32'd0);
    chk("t3 len0 writes", 32'(n_wr - w0), 32'd0);
    r0 = n_rd; w0 = n_wr;
    run("t3 len40", 40, 17, 0, lat);
    chk("t3 len40 reads", 32'(n_rd - r0), 32'd32);
    chk("t3 len40 writes", 32'(n_wr - w0), 32'd32);
    chk("t3 len40 latency", 32'(lat), 32'd34);

    // Backpressure with Start pulses during DONE and at the handshake
    run("t4", 3, 5, 10, lat);

    // Back-to-back: second result must not include the first accumulation
    for (int i = 0; i < 32; i++) begin
      cmem[i] = 24'h400000;
      smem[i] = 24'h000000;
    end
    smem[10] = 24'h400000;
    smem[9]  = 24'h200000;
    run("t5 first", 2, 10, 0, lat);
    chk("t5 first value", 32'(golden(2, 10)), 32'h300000);
    run("t5 second", 1, 9, 0, lat);
    chk("t5 second value", 32'(golden(1, 9)), 32'h100000);

    // Reset during the third RUN cycle
    len = LW'(8); base = AW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6 running", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    w0 = n_wr;
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 rd", 32'(mem_rd), 32'd0);
    chk("t6 caddr", 32'(caddr), 32'd0);
    chk("t6 saddr", 32'(saddr), 32'd0);
    chk("t6 clr", 32'(mac_clr), 32'd0);
    chk("t6 wr", 32'(mac_wr), 32'd0);
    chk("t6 res", 32'(res), 32'd0);
    chk("t6 vld", 32'(res_vld), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6 no wr after rst", 32'(n_wr - w0), 32'd0);
    run("t6 post", 2, 10, 0, lat);
    chk("t6 post latency", 32'(lat), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
